rtmq_gp_reg_bank: RTL and testbench
===================================

RTMQ_GP_REG_BANK -- requirements
Module: rtmq_gp_reg_bank

Interface
REQ-001 Parameter ADDR, default 0: base address; register i decodes at ADDR+i.
REQ-002 Parameter N_REG, default 4: number of registers, legal range 1..16.
REQ-003 Parameter CMT_ADDR, default ADDR+N_REG: commit-strobe address, used only when shadowing is compiled in.
REQ-004 Port clk  input  1  system clock; the only clock.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port alu_out  input  W_ALU  ALU bus {alu_res, alu_msk, alu_rda, alu_r0a, alu_r1a, imm_res, imm_rda, imm_seg}.
REQ-007 Port reg_out  output  N_REG*W_REG  register contents; register i occupies bits [i*W_REG +: W_REG].
REQ-008 Port f_trg  output  N_REG  per-register side-effect pulse.
REQ-009 Port f_cmt  output  1  one-cycle pulse after any commit; constant 0 without shadowing.

Function
REQ-010 Decode SHALL be registered: an address match on alu_rda or imm_rda in cycle t SHALL qualify the data fields in cycle t+1.
REQ-011 imm_seg SHALL be registered with imm_rda; imm_seg=1 selects a high write (bits [W_REG-1:W_LSG]) and imm_seg=0 selects a low write (bits [W_LSG-1:0]).
REQ-012 The write target in cycle t+1 SHALL be the live register without shadowing, or the shadow register with shadowing.
REQ-013 Write priority per register SHALL be imm-high, then imm-low, then ALU; a lower-priority write in the same cycle SHALL be dropped.
REQ-014 An ALU write SHALL produce target <= alu_res | (target & alu_msk).
REQ-015 An imm-high write SHALL replace only the high field; an imm-low write SHALL replace only the low field.
REQ-016 Without shadowing, reg_out SHALL show the new value in cycle t+2, giving 2-cycle latency from address.
REQ-017 Without shadowing, f_trg[i] SHALL pulse in cycle t+2 for imm-low or ALU writes to register i, and not for imm-high writes.
REQ-018 Writes to unmapped addresses SHALL have no effect.
REQ-019 Simultaneous writes to different registers in the same cycle, one via the A channel and one via the I channel, SHALL both take effect.

Configuration
REQ-020 Macro RTMQ_GPREG_SHADOW_EN SHALL compile in shadow registers and commit; when absent, no shadow flops or commit decode SHALL exist.
REQ-021 With the macro, an ALU or imm-low write to CMT_ADDR in cycle t+1 SHALL be a commit with mask m = written value bits [N_REG-1:0]; imm-high writes to CMT_ADDR SHALL be ignored.
REQ-022 A commit SHALL copy shadow i to live i for every i with m[i]=1, visible on reg_out at t+2.
REQ-023 A commit SHALL also pulse f_trg[i] at t+2 for every committed i, and pulse f_cmt at t+2.
REQ-024 With the macro, shadow writes SHALL NOT pulse f_trg.
REQ-025 If a shadow write and a commit of the same register coincide, the commit SHALL carry the newly written shadow value (write-through).
REQ-026 A commit with m=0 SHALL still pulse f_cmt and SHALL change no register.

Reset
REQ-027 With rst=1 at a clock edge, all live registers, shadows, decode stages, f_trg and f_cmt SHALL become 0 at the next cycle.
REQ-028 An access whose address stage preceded or coincided with rst SHALL be discarded.
REQ-029 Behaviour after rst deasserts SHALL match power-up, and all flops SHALL also initialise to 0.

Structure
REQ-030 W_ALU, W_REG, W_ADR and W_LSG and the alu_out field order SHALL come from the shared rtmq_pkg package; nothing SHALL be redefined locally.
REQ-031 Single-address decode plus registered write flags SHALL live in sub-module rtmq_acs_dec, instantiated N_REG times plus once for CMT_ADDR under the macro.

Verification
(Bench build: W_REG=32, W_LSG=16, ADDR=8, N_REG=4.)
REQ-032 ALU write to reg 1 with old=0x0000_00FF, res=0x1200_0000, msk=0x0000_000F -> reg_out[1]=0x1200_000F at t+2; f_trg=4'b0010 at t+2.
REQ-033 imm-high 0xABCD then imm-low 0x1234 to reg 0 -> 0xABCD_1234; f_trg[0] pulses only after the low write.
REQ-034 Same cycle: imm-high and ALU write to reg 2 -> only the high field changes; simultaneous writes to reg 0 and reg 3 via different channels -> both land.
REQ-035 Shadow build: write 0x55 to reg 0 and 0x66 to reg 3, then commit mask 0x9 -> both appear in the same cycle; f_trg=4'b1001 and f_cmt=1; reg 1 and reg 2 stay unchanged.
REQ-036 Shadow build: write to reg 2 coincident with commit mask 0x4 -> new value is live at t+2.
REQ-037 rst asserted between address and data cycle -> the write is lost, all outputs read 0, and the next write behaves normally.

Source files
------------

// File: rtl/rtmq_pkg.sv
// Shared RTMQ bus widths and the alu_out field layout used by every
// peripheral that snoops the ALU result bus.
package rtmq_pkg;

    localparam int W_REG = 32;
    localparam int W_LSG = 16;
    localparam int W_ADR = 8;

    // Field order of alu_out, MSB first.
    typedef struct packed {
        logic [W_REG-1:0] alu_res;
        logic [W_REG-1:0] alu_msk;
        logic [W_ADR-1:0] alu_rda;
        logic [W_ADR-1:0] alu_r0a;
        logic [W_ADR-1:0] alu_r1a;
        logic [W_REG-1:0] imm_res;
        logic [W_ADR-1:0] imm_rda;
        logic             imm_seg;
    } alu_bus_t;

    localparam int W_ALU = $bits(alu_bus_t);

endpackage

// File: rtl/rtmq_acs_dec.sv
// Single-address access decoder: compares both destination addresses
// against ADDR and registers the resulting write flags for the data cycle.
module rtmq_acs_dec
    import rtmq_pkg::*;
#(
    parameter int ADDR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_ADR-1:0] alu_rda,
    input  logic [W_ADR-1:0] imm_rda,
    input  logic             imm_seg,
    output logic             alu_wr,
    output logic             imh_wr,
    output logic             iml_wr
);

    logic alu_q = 1'b0;
    logic imh_q = 1'b0;
    logic iml_q = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q <= 1'b0;
            imh_q <= 1'b0;
            iml_q <= 1'b0;
        end else begin
            alu_q <= (alu_rda == W_ADR'(ADDR));
            imh_q <= (imm_rda == W_ADR'(ADDR)) && imm_seg;
            iml_q <= (imm_rda == W_ADR'(ADDR)) && !imm_seg;
        end
    end

    assign alu_wr = alu_q;
    assign imh_wr = imh_q;
    assign iml_wr = iml_q;

endmodule

// File: rtl/rtmq_gp_reg_bank.sv
// General-purpose register bank on the RTMQ ALU bus. Define
// RTMQ_GPREG_SHADOW_EN to add shadow registers with a commit strobe at CMT_ADDR.
module rtmq_gp_reg_bank
    import rtmq_pkg::*;
#(
    parameter int ADDR     = 0,
    parameter int N_REG    = 4,
    parameter int CMT_ADDR = ADDR + N_REG
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W_ALU-1:0]       alu_out,
    output logic [N_REG*W_REG-1:0] reg_out,
    output logic [N_REG-1:0]       f_trg,
    output logic                   f_cmt
);

    alu_bus_t bus;
    assign bus = alu_bus_t'(alu_out);

    logic [N_REG-1:0] alu_wr;
    logic [N_REG-1:0] imh_wr;
    logic [N_REG-1:0] iml_wr;

    logic [W_REG-1:0] live [N_REG] = '{default: '0};
    logic [W_REG-1:0] tgt  [N_REG];
    logic [W_REG-1:0] nxt  [N_REG];
    logic [N_REG-1:0] trg_q = '0;

    for (genvar g = 0; g < N_REG; g++) begin : g_reg
        rtmq_acs_dec #(.ADDR(ADDR + g)) u_dec (
            .clk    (clk),
            .rst    (rst),
            .alu_rda(bus.alu_rda),
            .imm_rda(bus.imm_rda),
            .imm_seg(bus.imm_seg),
            .alu_wr (alu_wr[g]),
            .imh_wr (imh_wr[g]),
            .iml_wr (iml_wr[g])
        );
        assign reg_out[g*W_REG +: W_REG] = live[g];
    end

    // Merge the data-cycle fields into the write target; imm-high beats
    // imm-low beats ALU, and the loser of a collision is simply dropped.
    always_comb begin
        for (int i = 0; i < N_REG; i++) begin
            nxt[i] = tgt[i];
            if (imh_wr[i])
                nxt[i] = {bus.imm_res[W_REG-1:W_LSG], tgt[i][W_LSG-1:0]};
            else if (iml_wr[i])
                nxt[i] = {tgt[i][W_REG-1:W_LSG], bus.imm_res[W_LSG-1:0]};
            else if (alu_wr[i])
                nxt[i] = bus.alu_res | (tgt[i] & bus.alu_msk);
        end
    end

    assign f_trg = trg_q;

`ifdef RTMQ_GPREG_SHADOW_EN
    logic [W_REG-1:0] shd [N_REG] = '{default: '0};
    logic             c_alu;
    logic             c_imh;
    logic             c_iml;
    logic             cmt;
    logic [N_REG-1:0] cmask;
    logic             cmt_q = 1'b0;
    logic             unused_bits;

    rtmq_acs_dec #(.ADDR(CMT_ADDR)) u_cmt_dec (
        .clk    (clk),
        .rst    (rst),
        .alu_rda(bus.alu_rda),
        .imm_rda(bus.imm_rda),
        .imm_seg(bus.imm_seg),
        .alu_wr (c_alu),
        .imh_wr (c_imh),
        .iml_wr (c_iml)
    );

    always_comb begin
        for (int i = 0; i < N_REG; i++)
            tgt[i] = shd[i];
    end

    // An imm-high write to the commit address carries no mask and is ignored.
    assign cmt   = c_alu | c_iml;
    assign cmask = c_iml ? bus.imm_res[N_REG-1:0] : bus.alu_res[N_REG-1:0];

    // Committed registers take nxt rather than shd so a coincident shadow
    // write lands in the live register in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REG; i++) begin
                shd[i]  <= '0;
                live[i] <= '0;
            end
            trg_q <= '0;
            cmt_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                shd[i] <= nxt[i];
                if (cmt && cmask[i])
                    live[i] <= nxt[i];
            end
            trg_q <= cmt ? cmask : '0;
            cmt_q <= cmt;
        end
    end

    assign f_cmt       = cmt_q;
    assign unused_bits = ^{c_imh, bus.alu_r0a, bus.alu_r1a};
`else
    logic unused_bits;

    always_comb begin
        for (int i = 0; i < N_REG; i++)
            tgt[i] = live[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REG; i++)
                live[i] <= '0;
            trg_q <= '0;
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                live[i]  <= nxt[i];
                trg_q[i] <= !imh_wr[i] && (iml_wr[i] || alu_wr[i]);
            end
        end
    end

    assign f_cmt       = 1'b0;
    assign unused_bits = ^{bus.alu_r0a, bus.alu_r1a, W_ADR'(CMT_ADDR)};
`endif

endmodule

// File: tb/tb_rtmq_gp_reg_bank.sv
// Self-checking bench for rtmq_gp_reg_bank (ADDR=8, N_REG=4); build with
// RTMQ_GPREG_SHADOW_EN defined to exercise the shadow/commit variant.
module tb_rtmq_gp_reg_bank;
    import rtmq_pkg::*;

    localparam int ADDR  = 8;
    localparam int N_REG = 4;
    localparam int CMT   = ADDR + N_REG;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [W_ALU-1:0]       alu_out = '0;
    logic [N_REG*W_REG-1:0] reg_out;
    logic [N_REG-1:0]       f_trg;
    logic                   f_cmt;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference state: what each register holds and which strobes are due.
    logic [31:0] m_live [N_REG];
    logic [31:0] m_shd  [N_REG];
    logic [3:0]  m_trg;
    logic        m_cmt;
    int          prev_alu = -1;
    int          prev_imm = -1;
    bit          prev_seg = 1'b0;
    bit          shadow_build;

    rtmq_gp_reg_bank #(.ADDR(ADDR), .N_REG(N_REG)) dut (
        .clk    (clk),
        .rst    (rst),
        .alu_out(alu_out),
        .reg_out(reg_out),
        .f_trg  (f_trg),
        .f_cmt  (f_cmt)
    );

    always #5 clk = ~clk;

    function automatic alu_bus_t mk(input logic [7:0] ar, input logic [31:0] res,
                                    input logic [31:0] msk, input logic [7:0] ir,
                                    input logic [31:0] iv, input logic seg);
        alu_bus_t b;
        b.alu_res = res;
        b.alu_msk = msk;
        b.alu_rda = ar;
        b.alu_r0a = 8'h00;
        b.alu_r1a = 8'h00;
        b.imm_res = iv;
        b.imm_rda = ir;
        b.imm_seg = seg;
        return b;
    endfunction

    // Register slot for an address: 0..N_REG-1, N_REG for the commit strobe, -1 unmapped.
    function automatic int slot_of(input logic [7:0] a);
        int ai;
        ai = int'(a);
        if (ai >= ADDR && ai < ADDR + N_REG) return ai - ADDR;
        if (ai == CMT) return N_REG;
        return -1;
    endfunction

    // One clock of the reference: writes addressed last cycle use this cycle's data.
    task automatic model_step(input alu_bus_t b, input logic r);
        logic [31:0] base;
        logic [31:0] v;
        logic [3:0]  mask;
        bit          commit;
        if (r) begin
            for (int i = 0; i < N_REG; i++) begin
                m_live[i] = 32'h0;
                m_shd[i]  = 32'h0;
            end
            m_trg = 4'h0;
            m_cmt = 1'b0;
            prev_alu = -1;
            prev_imm = -1;
            prev_seg = 1'b0;
            return;
        end
        m_trg = 4'h0;
        m_cmt = 1'b0;
        for (int i = 0; i < N_REG; i++) begin
            base = shadow_build ? m_shd[i] : m_live[i];
            v = base;
            if (prev_imm == i && prev_seg)
                v = {b.imm_res[31:16], base[15:0]};
            else if (prev_imm == i)
                v = {base[31:16], b.imm_res[15:0]};
            else if (prev_alu == i) begin
                v = b.alu_res | (base & b.alu_msk);
            end
            if (shadow_build)
                m_shd[i] = v;
            else begin
                m_live[i] = v;
                if ((prev_imm == i && !prev_seg) || (prev_alu == i && prev_imm != i))
                    m_trg[i] = 1'b1;
            end
        end
        if (shadow_build) begin
            commit = 1'b0;
            mask   = 4'h0;
            if (prev_imm == N_REG && !prev_seg) begin
                commit = 1'b1;
                mask   = b.imm_res[3:0];
            end else if (prev_alu == N_REG) begin
                commit = 1'b1;
                mask   = b.alu_res[3:0];
            end
            if (commit) begin
                for (int i = 0; i < N_REG; i++)
                    if (mask[i]) m_live[i] = m_shd[i];
                m_trg = mask;
                m_cmt = 1'b1;
            end
        end
        prev_alu = slot_of(b.alu_rda);
        prev_imm = slot_of(b.imm_rda);
        prev_seg = b.imm_seg;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        for (int i = 0; i < N_REG; i++)
            check_eq($sformatf("%s reg%0d", tag, i), reg_out[i*W_REG +: W_REG], m_live[i]);
        check_eq({tag, " f_trg"}, 32'(f_trg), 32'(m_trg));
        check_eq({tag, " f_cmt"}, 32'(f_cmt), 32'(m_cmt));
    endtask

    // Drive one cycle of bus/reset, advance the model at the edge, check just after it.
    task automatic apply_stimulus(input string tag, input alu_bus_t b, input logic r);
        alu_out = b;
        rst     = r;
        @(posedge clk);
        model_step(b, r);
        #1;
        check_output(tag);
    endtask

    initial begin
        alu_bus_t idle;
        alu_bus_t rb;
`ifdef RTMQ_GPREG_SHADOW_EN
        shadow_build = 1'b1;
`else
        shadow_build = 1'b0;
`endif
        idle = mk(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 1'b0);
        $display("[TB] start, shadow_build=%0d", shadow_build);

        apply_stimulus("reset0", idle, 1'b1);
        apply_stimulus("reset1", idle, 1'b1);
        apply_stimulus("idle", idle, 1'b0);

        // ALU read-modify-write on reg 1 after preloading 0xFF.
        apply_stimulus("r1 ld addr", mk(8'h00, 0, 0, 8'd9, 0, 1'b0), 1'b0);
        apply_stimulus("r1 ld data", mk(8'h00, 0, 0, 8'h00, 32'h0000_00FF, 1'b0), 1'b0);
        apply_stimulus("r1 alu addr", mk(8'd9, 0, 0, 8'h00, 0, 1'b0), 1'b0);
        apply_stimulus("r1 alu data", mk(8'h00, 32'h1200_0000, 32'h0000_000F, 8'h00, 0, 1'b0), 1'b0);
`ifndef RTMQ_GPREG_SHADOW_EN
        check_eq("alu rmw reg1", reg_out[1*W_REG +: W_REG], 32'h1200_000F);
        check_eq("alu rmw f_trg", 32'(f_trg), 32'h2);
`endif

        // imm-high then imm-low on reg 0.
        apply_stimulus("r0 hi addr", mk(8'h00, 0, 0, 8'd8, 0, 1'b1), 1'b0);
        apply_stimulus("r0 hi data", mk(8'h00, 0, 0, 8'h00, 32'hABCD_0000, 1'b0), 1'b0);
        check_eq("imm hi no trg", 32'(f_trg), 32'h0);
        apply_stimulus("r0 lo addr", mk(8'h00, 0, 0, 8'd8, 0, 1'b0), 1'b0);
        apply_stimulus("r0 lo data", mk(8'h00, 0, 0, 8'h00, 32'h0000_1234, 1'b0), 1'b0);
`ifndef RTMQ_GPREG_SHADOW_EN
        check_eq("imm hi+lo reg0", reg_out[0 +: W_REG], 32'hABCD_1234);
        check_eq("imm lo f_trg", 32'(f_trg), 32'h1);
`endif

        // imm-high beats ALU on reg 2; then ALU->reg0 and imm-low->reg3 together.
        apply_stimulus("r2 col addr", mk(8'd10, 0, 0, 8'd10, 0, 1'b1), 1'b0);
        apply_stimulus("r2 col data", mk(8'h00, 32'hFFFF_FFFF, 32'h0, 8'h00, 32'h5A5A_0000, 1'b0), 1'b0);
        apply_stimulus("dual addr", mk(8'd8, 0, 0, 8'd11, 0, 1'b0), 1'b0);
        apply_stimulus("dual data", mk(8'h00, 32'h0000_0077, 32'h0, 8'h00, 32'h0000_BEEF, 1'b0), 1'b0);
`ifndef RTMQ_GPREG_SHADOW_EN
        check_eq("collision reg2", reg_out[2*W_REG +: W_REG], 32'h5A5A_0000);
        check_eq("dual reg0", reg_out[0 +: W_REG], 32'h0000_0077);
        check_eq("dual reg3", reg_out[3*W_REG +: W_REG], 32'h0000_BEEF);
        check_eq("dual f_trg", 32'(f_trg), 32'h9);
`endif

        // Unmapped addresses just below and just above the bank.
        apply_stimulus("unmap addr", mk(8'd7, 0, 0, 8'd12, 0, 1'b0), 1'b0);
        apply_stimulus("unmap data", mk(8'h00, 32'hFFFF_FFFF, 32'h0, 8'h00, 32'h0000_0000, 1'b0), 1'b0);

`ifdef RTMQ_GPREG_SHADOW_EN
        // Shadow writes stay hidden until a commit of mask 0x9.
        apply_stimulus("shd addr", mk(8'd8, 0, 0, 8'd11, 0, 1'b0), 1'b0);
        apply_stimulus("shd data", mk(8'h00, 32'h55, 32'h0, 8'h00, 32'h66, 1'b0), 1'b0);
        check_eq("shd hidden f_trg", 32'(f_trg), 32'h0);
        apply_stimulus("cmt addr", mk(8'd12, 0, 0, 8'h00, 0, 1'b0), 1'b0);
        apply_stimulus("cmt data", mk(8'h00, 32'h9, 32'h0, 8'h00, 0, 1'b0), 1'b0);
        check_eq("cmt reg0", reg_out[0 +: W_REG], 32'h55);
        check_eq("cmt reg3", reg_out[3*W_REG +: W_REG], 32'h66);
        check_eq("cmt f_trg", 32'(f_trg), 32'h9);
        check_eq("cmt f_cmt", 32'(f_cmt), 32'h1);
        // Write-through: shadow write to reg 2 coincides with commit 0x4.
        apply_stimulus("wt addr", mk(8'd10, 0, 0, 8'd12, 0, 1'b0), 1'b0);
        apply_stimulus("wt data", mk(8'h00, 32'h0000_0777, 32'h0, 8'h00, 32'h4, 1'b0), 1'b0);
        check_eq("wt reg2", reg_out[2*W_REG +: W_REG], 32'h0000_0777);
        // Empty commit still strobes f_cmt.
        apply_stimulus("cmt0 addr", mk(8'd12, 0, 0, 8'h00, 0, 1'b0), 1'b0);
        apply_stimulus("cmt0 data", mk(8'h00, 32'h0, 32'h0, 8'h00, 0, 1'b0), 1'b0);
        check_eq("cmt0 f_cmt", 32'(f_cmt), 32'h1);
        check_eq("cmt0 f_trg", 32'(f_trg), 32'h0);
`endif

        // Reset landing between address and data cycle kills the write.
        apply_stimulus("rstmid addr", mk(8'h00, 0, 0, 8'd9, 0, 1'b0), 1'b0);
        apply_stimulus("rstmid data", mk(8'h00, 0, 0, 8'h00, 32'h0000_DEAD, 1'b0), 1'b1);
        check_eq("rstmid reg1", reg_out[1*W_REG +: W_REG], 32'h0);
        apply_stimulus("post rst idle", idle, 1'b0);
        check_eq("post rst reg1", reg_out[1*W_REG +: W_REG], 32'h0);
        apply_stimulus("post rst addr", mk(8'h00, 0, 0, 8'd9, 0, 1'b0), 1'b0);
        apply_stimulus("post rst data", mk(8'h00, 0, 0, 8'h00, 32'h0000_0042, 1'b0), 1'b0);
`ifndef RTMQ_GPREG_SHADOW_EN
        check_eq("post rst write", reg_out[1*W_REG +: W_REG], 32'h0000_0042);
        check_eq("post rst f_trg", 32'(f_trg), 32'h2);
`endif

        // Random traffic around the bank, commit strobe and neighbours.
        for (int n = 0; n < 400; n++) begin
            rb = mk(8'($urandom_range(6, 13)), $urandom, $urandom,
                    8'($urandom_range(6, 13)), $urandom, 1'($urandom_range(0, 1)));
            apply_stimulus("random", rb, ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
